// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 receiver: FSM states, frame constants
// and the odd-parity check.
package ps2_pkg;

  localparam int unsigned PS2_DATA_BITS = 8;
  localparam int unsigned BIT_CNT_W     = $clog2(PS2_DATA_BITS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // True when data plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                         input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Small scan-code FIFO; a pop in the same cycle frees room for a push when full.
module ps2_sync_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push_i,
  input  logic [PS2_DATA_BITS-1:0]    data_i,
  input  logic                        pop_i,
  output logic [PS2_DATA_BITS-1:0]    head_c,
  output logic [$clog2(DEPTH):0]      count_o,
  output logic                        full_c,
  output logic                        empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [PS2_DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]            wr_ptr_q;
  logic [AW-1:0]            rd_ptr_q;
  logic [CW-1:0]            count_q;
  logic                     do_pop;
  logic                     do_push;

  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_c;
  assign do_push = push_i && (!full_c || do_pop);

  assign head_c  = empty_c ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver feeding a scan-code FIFO with sticky error flags.
// Optional mid-frame timeout is enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          clr,
  output logic [PS2_DATA_BITS-1:0]      rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          parity_err,
  output logic                          frame_err
);

  logic [SYNC_STAGES-1:0]   clk_sync_q;
  logic [SYNC_STAGES-1:0]   dat_sync_q;
  logic                     clk_prev_q;
  logic                     clk_s;
  logic                     dat_s;
  logic                     fall_c;
  logic                     clr_q;
  logic                     pop_edge_c;

  ps2_state_e               state_q;
  logic [BIT_CNT_W-1:0]     bit_cnt_q;
  logic [PS2_DATA_BITS-1:0] shreg_q;
  logic                     par_q;

  logic                     stop_fall_c;
  logic                     par_ok_c;
  logic                     push_c;
  logic                     timeout_c;
  logic                     full_c;
  logic                     empty_c;

  logic                     ovf_q;
  logic                     perr_q;
  logic                     ferr_q;

  // Pin synchronizers idle high, matching the released bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
      clr_q      <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q <= clk_s;
      clr_q      <= clr;
    end
  end

  assign clk_s      = clk_sync_q[SYNC_STAGES-1];
  assign dat_s      = dat_sync_q[SYNC_STAGES-1];
  assign fall_c     = clk_prev_q && !clk_s;
  assign pop_edge_c = clr && !clr_q;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_q;

  always_ff @(posedge clk) begin
    if (rst || state_q == ST_IDLE || fall_c) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TMO_W'(1);
    end
  end

  assign timeout_c = (state_q != ST_IDLE) && !fall_c &&
                     (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo_c;
  assign unused_tmo_c = (TIMEOUT_CYCLES == 0);
  assign timeout_c    = 1'b0;
`endif

  // Frame FSM: advances only on synchronized PS/2 clock falling edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
    end else if (timeout_c) begin
      state_q <= ST_IDLE;
    end else if (fall_c) begin
      case (state_q)
        ST_IDLE: begin
          if (!dat_s) begin
            state_q   <= ST_DATA;
            bit_cnt_q <= '0;
          end
        end
        ST_DATA: begin
          shreg_q   <= {dat_s, shreg_q[PS2_DATA_BITS-1:1]};
          bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == BIT_CNT_W'(PS2_DATA_BITS - 1)) state_q <= ST_PARITY;
        end
        ST_PARITY: begin
          par_q   <= dat_s;
          state_q <= ST_STOP;
        end
        ST_STOP:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign stop_fall_c = fall_c && (state_q == ST_STOP);
  assign par_ok_c    = odd_parity_ok(shreg_q, par_q);
  assign push_c      = stop_fall_c && dat_s && par_ok_c;

  // Sticky flags: any set in a cycle beats a clear from the pop edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q  <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      if (push_c && full_c && !pop_edge_c) ovf_q <= 1'b1;
      else if (pop_edge_c)                 ovf_q <= 1'b0;

      if (stop_fall_c && !par_ok_c) perr_q <= 1'b1;
      else if (pop_edge_c)          perr_q <= 1'b0;

      if ((stop_fall_c && !dat_s) || timeout_c) ferr_q <= 1'b1;
      else if (pop_edge_c)                      ferr_q <= 1'b0;
    end
  end

  ps2_sync_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .data_i  (shreg_q),
    .pop_i   (pop_edge_c),
    .head_c  (rx_data),
    .count_o (fifo_count),
    .full_c  (full_c),
    .empty_c (empty_c)
  );

  assign rx_valid   = !empty_c;
  assign overflow   = ovf_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Self-checking bench for ps2_receiver: frame table with a byte scoreboard plus
// hand sequences for held clr, pop-at-stop when full, mid-frame reset and timeout.
module tb_ps2_receiver;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 300;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       clr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       parity_err;
  logic       frame_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb_q[$];

  ps2_receiver #(
    .FIFO_DEPTH     (DEPTH),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .clr        (clr),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] data;
    bit         par_good;
    bit         stop;
    int         exp_count;
    bit         exp_perr;
    bit         exp_ferr;
    bit         exp_ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives nbits of a frame; optionally raises clr so its edge meets the stop-bit fall.
  task automatic send_frame(input logic [7:0] d, input bit par_good, input bit stop,
                            input int nbits, input bit pop_at_stop);
    logic [10:0] bits;
    bits = {stop, (par_good ? ~^d : ^d), d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = bits[i];
      wait_n(3);
      ps2_clk = 1'b0;
      if (i == 10 && pop_at_stop) begin
        wait_n(2);
        clr = 1'b1;
        wait_n(1);
        clr = 1'b0;
        wait_n(2);
      end else begin
        wait_n(5);
      end
      ps2_clk = 1'b1;
      wait_n(3);
    end
    ps2_data = 1'b1;
    wait_n(4);
  endtask

  task automatic pop_once();
    clr = 1'b1;
    wait_n(1);
    clr = 1'b0;
    wait_n(1);
  endtask

  task automatic sb_send(input logic [7:0] d, input bit par_good, input bit stop);
    if (par_good && stop && sb_q.size() < DEPTH) sb_q.push_back(d);
    send_frame(d, par_good, stop, 11, 1'b0);
  endtask

  task automatic check_head(input string name);
    if (sb_q.size() == 0) check(name, {24'd0, rx_data}, 32'h00);
    else                  check(name, {24'd0, rx_data}, {24'd0, sb_q[0]});
  endtask

  initial begin
    logic [7:0] exp_b;
    int         exp_c;

    vecs[0] = '{8'h1C, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'hF0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h5A, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'hF0, 1'b1, 1'b1, 2, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h1C, 1'b1, 1'b1, 3, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h29, 1'b1, 1'b1, 4, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{8'h5A, 1'b1, 1'b1, 4, 1'b1, 1'b1, 1'b1};

    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; clr = 1'b0;
    wait_n(4);
    rst = 1'b0;
    wait_n(1);
    check("reset rx_data", {24'd0, rx_data}, 32'h00);
    check("reset rx_valid", {31'd0, rx_valid}, 0);
    check("reset count", {29'd0, fifo_count}, 0);
    check("reset flags", {29'd0, overflow, parity_err, frame_err}, 0);

    for (int i = 0; i < 7; i++) begin
      sb_send(vecs[i].data, vecs[i].par_good, vecs[i].stop);
      check($sformatf("vec%0d count", i), {29'd0, fifo_count}, vecs[i].exp_count);
      check($sformatf("vec%0d rx_valid", i), {31'd0, rx_valid}, 1);
      check($sformatf("vec%0d parity_err", i), {31'd0, parity_err}, {31'd0, vecs[i].exp_perr});
      check($sformatf("vec%0d frame_err", i), {31'd0, frame_err}, {31'd0, vecs[i].exp_ferr});
      check($sformatf("vec%0d overflow", i), {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
      check_head($sformatf("vec%0d head", i));
    end

    // Full FIFO: pop edge coincides with the stop-bit fall, so the push lands.
    void'(sb_q.pop_front());
    sb_q.push_back(8'h33);
    send_frame(8'h33, 1'b1, 1'b1, 11, 1'b1);
    check("pop+push full count", {29'd0, fifo_count}, 4);
    check("pop+push full flags", {29'd0, overflow, parity_err, frame_err}, 0);
    check_head("pop+push full head");

    while (sb_q.size() > 0) begin
      exp_b = sb_q.pop_front();
      check("drain head", {24'd0, rx_data}, {24'd0, exp_b});
      exp_c = sb_q.size();
      pop_once();
      check("drain count", {29'd0, fifo_count}, exp_c);
    end
    check("empty rx_valid", {31'd0, rx_valid}, 0);
    check("empty rx_data", {24'd0, rx_data}, 32'h00);
    pop_once();
    check("empty pop count", {29'd0, fifo_count}, 0);

    // Bad parity with nothing queued; an empty-FIFO pop still clears the flag.
    sb_send(8'hF0, 1'b0, 1'b1);
    check("bad parity count", {29'd0, fifo_count}, 0);
    check("bad parity flag", {31'd0, parity_err}, 1);
    pop_once();
    check("bad parity cleared", {31'd0, parity_err}, 0);

    // Held clr pops exactly once.
    sb_send(8'h1C, 1'b1, 1'b1);
    sb_send(8'h5A, 1'b1, 1'b1);
    check("hold pre count", {29'd0, fifo_count}, 2);
    clr = 1'b1;
    wait_n(10);
    clr = 1'b0;
    wait_n(1);
    void'(sb_q.pop_front());
    check("hold post count", {29'd0, fifo_count}, 1);
    check_head("hold post head");

    // Reset mid-frame abandons the frame and the queue.
    send_frame(8'h29, 1'b1, 1'b1, 6, 1'b0);
    rst = 1'b1;
    wait_n(2);
    rst = 1'b0;
    sb_q.delete();
    wait_n(1);
    check("midrst count", {29'd0, fifo_count}, 0);
    check("midrst valid", {31'd0, rx_valid}, 0);
    check("midrst flags", {29'd0, overflow, parity_err, frame_err}, 0);
    sb_send(8'h5A, 1'b1, 1'b1);
    check("post rst count", {29'd0, fifo_count}, 1);
    check_head("post rst head");
    pop_once();
    void'(sb_q.pop_front());

`ifdef PS2_RX_TIMEOUT_EN
    send_frame(8'h29, 1'b1, 1'b1, 5, 1'b0);
    wait_n(TMO + 20);
    check("timeout frame_err", {31'd0, frame_err}, 1);
    check("timeout count", {29'd0, fifo_count}, 0);
    sb_send(8'h29, 1'b1, 1'b1);
    check("after timeout count", {29'd0, fifo_count}, 1);
    check_head("after timeout head");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_receiver.md
# ps2_receiver

Receives PS/2 device-to-host frames from the keyboard pins, validates the frame, and queues the received scan codes in a small FIFO. It sits directly upstream of the 68k bus interface. The head byte drives that interface's `read_reg` input. The interface's `clr` read strobe pops the head.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: scan-code FIFO entries; must be a power of 2 and at least 2.
- `SYNC_STAGES`, default 2: flops in each pin synchronizer chain.
- `TIMEOUT_CYCLES`, default 20000: idle `clk` cycles allowed mid-frame. Used only with `PS2_RX_TIMEOUT_EN`.

Ports (one clock, `clk`; reset `rst` is synchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous.
- `clr`  in  1  pop request from the bus interface.
- `rx_data`  out  8  FIFO head byte; 8'h00 when the FIFO is empty.
- `rx_valid`  out  1  FIFO not empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of bytes queued.
- `overflow`  out  1  sticky flag: a byte was dropped because the FIFO was full.
- `parity_err`  out  1  sticky flag: a frame failed the odd-parity check.
- `frame_err`  out  1  sticky flag: bad stop bit, or timeout.

## Operation
- Each pin passes through `SYNC_STAGES` flops. The synchronizer flops reset to 1, the bus idle level.
- A falling edge is detected when the registered copy of the synced clock is 1 and the synced clock is now 0. This produces a 1-cycle `fall` pulse.
- Frame format: start bit (0), 8 data bits LSB first, odd parity bit, stop bit (1).
- The FSM samples synced data only on `fall`:
  - IDLE: data 0 → DATA, bit count cleared. Data 1 → stay in IDLE; this is a glitch, no flag.
  - DATA: shift the bit into `shreg[7]` and shift right. After the 8th bit → PARITY.
  - PARITY: latch the parity bit → STOP.
  - STOP: push the byte if stop is 1 and the count of ones over data+parity is odd.
    - Parity bad → set `parity_err`, discard the byte.
    - Stop bit 0 → set `frame_err`, discard the byte.
    - Both bad → set both flags.
    - In every case → IDLE.
- Pop: fires on the rising edge of `clr` (`clr & ~clr_q`). A multi-cycle `clr` pops exactly once. A pop on an empty FIFO is ignored.
- All three sticky flags are cleared on every pop edge, including a pop on an empty FIFO. If the same cycle also sets a flag, the set wins.
- Push while full:
  - Byte is dropped and `overflow` is set, unless a pop edge occurs in the same cycle.
  - If a pop edge occurs in the same cycle, the pop is processed first, the push succeeds, and the count is unchanged.
- Simultaneous push and pop on a non-empty FIFO leaves the count unchanged.
- Read and write pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally; the count tracks full/empty.

## Timing
- Reset values: `rx_data`=8'h00, `rx_valid`=0, `fifo_count`=0, all flags 0, FSM in IDLE, bit count 0, `clr_q`=0.
- Reset mid-frame abandons the partial frame; no flag is set.
- `fall` asserts SYNC_STAGES+1 `clk` cycles after the pin falls.
- Stop-bit `fall` in cycle T: the FIFO write and the flag updates take effect at the end of T. `rx_valid`/`rx_data`/`fifo_count` reflect them from T+1.
- `clr` rising edge detected in cycle T: the next head byte (or 8'h00) and the decremented count are visible from T+1.
- `rx_data` is driven from registered state; there is no combinational path from `clr` to `rx_data`.

## Configuration
- `PS2_RX_TIMEOUT_EN` defined:
  - A counter runs while the FSM is in DATA, PARITY or STOP, and resets on each `fall`.
  - If it reaches `TIMEOUT_CYCLES`, the FSM returns to IDLE, `frame_err` is set, and the partial byte is discarded.
- `PS2_RX_TIMEOUT_EN` undefined: no counter is instantiated and the FSM waits indefinitely for the next edge.

## Structure
- Package `ps2_pkg`:
  - FSM state enum (IDLE, DATA, PARITY, STOP).
  - `PS2_DATA_BITS`=8.
  - Odd-parity helper function.
- Sub-module `ps2_sync_fifo`: depth-parameterised, 8-bit FIFO with push/pop, count, full/empty, and the pop-before-push rule when full.
- Synchronizer, edge detect and FSM live in the top module.

## Test plan
- Send frame 0x1C (parity 0, stop 1) → `rx_valid`=1, `rx_data`=8'h1C, `fifo_count`=1, no flags set.
- Send 0xF0 with parity 0 (wrong) → nothing queued, `parity_err`=1. A following `clr` pulse clears it.
- Send 0x1C, 0xF0, 0x1C, 0x5A, 0x29 with `FIFO_DEPTH`=4 →
  - `fifo_count`=4 and `overflow`=1.
  - Popping yields 1C, F0, 1C, 5A, then `rx_valid`=0 and `rx_data`=00.
- Hold `clr` high for 10 cycles with 2 bytes queued → exactly one pop; `fifo_count` goes 2→1.
- Stop bit sent as 0 → `frame_err`=1, nothing queued. Assert `rst` mid-frame → all outputs return to reset values, and the next clean 0x5A frame is received correctly.
- With `PS2_RX_TIMEOUT_EN`: stop clocking after 4 data bits → after `TIMEOUT_CYCLES` `frame_err`=1, and the next 0x29 frame is received correctly.
